// File: rtl/toy_mem_responder.sv
// Word-addressed memory responder serving instruction and data ports.
// Clears itself after reset and accepts preload writes on a load port.
module toy_mem_responder #(
    parameter int          AW   = 10,
    parameter logic [31:0] FILL = 32'h0000_0000
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          IREQ,
    input  logic [29:0]   IADDR,
    output logic [31:0]   INSTR,
    input  logic          DREQ,
    input  logic          DRW,
    input  logic [29:0]   DADDR,
    input  logic [31:0]   DWDATA,
    output logic [31:0]   DRDATA,
    input  logic          LDEN,
    input  logic [AW-1:0] LDADDR,
    input  logic [31:0]   LDDATA,
    output logic          LDACK,
    output logic          INIT_DONE,
    output logic          ERR
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_e;

    state_e        state_q;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;
    logic [31:0]   instr_q;
    logic [31:0]   instr_d;
    logic [31:0]   drdata_q;
    logic [31:0]   drdata_d;
    logic          done_q;
    logic          err_q;
    logic [31:0]   mem_q [DEPTH];

    logic          run;
    logic          i_oor;
    logic          d_oor;
    logic [AW-1:0] i_idx;
    logic [AW-1:0] d_idx;
    logic          d_wr;
    logic          d_rd;
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;

    assign run   = (state_q == S_RUN);
    assign i_oor = (IADDR[29:AW] != '0);
    assign d_oor = (DADDR[29:AW] != '0);
    assign i_idx = IADDR[AW-1:0];
    assign d_idx = DADDR[AW-1:0];
    assign d_wr  = DREQ & ~DRW;
    assign d_rd  = DREQ & DRW;
    assign cnt_d = cnt_q + AW'(1);

    // Out-of-range reads return zero instead of aliasing into the array.
    assign instr_d  = i_oor ? 32'h0 : mem_q[i_idx];
    assign drdata_d = d_oor ? 32'h0 : mem_q[d_idx];

    // A data write owns the single write port, so the load port backs off.
    assign LDACK = run & LDEN & ~d_wr;

    // Select the one write per edge: clear fill, data write, then load.
    always_comb begin
        we    = 1'b0;
        waddr = cnt_q;
        wdata = FILL;
        if (!run) begin
            we = 1'b1;
        end else if (d_wr) begin
            we    = ~d_oor;
            waddr = d_idx;
            wdata = DWDATA;
        end else if (LDACK) begin
            we    = 1'b1;
            waddr = LDADDR;
            wdata = LDDATA;
        end
    end

    // Storage array; reads elsewhere see the pre-edge contents.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Clear sequencer and registered read/status outputs.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= S_INIT;
            cnt_q    <= '0;
            instr_q  <= 32'h0;
            drdata_q <= 32'h0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_INIT: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == '1) begin
                        state_q <= S_RUN;
                        done_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (IREQ) begin
                        instr_q <= instr_d;
                    end
                    if (d_rd) begin
                        drdata_q <= drdata_d;
                    end
                    if ((IREQ & i_oor) | (DREQ & d_oor)) begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_INIT;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign INSTR     = instr_q;
    assign DRDATA    = drdata_q;
    assign INIT_DONE = done_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_toy_mem_responder.sv
// Scoreboard bench for toy_mem_responder with a word-array reference model.
// Driver pushes expected responses; a monitor pops them after each edge.
module tb_toy_mem_responder;

    localparam int          TAW   = 4;
    localparam int          TD    = 16;
    localparam logic [31:0] TFILL = 32'hC0DE_F111;

    logic        CLK;
    logic        RSTN;
    logic        IREQ;
    logic [29:0] IADDR;
    logic [31:0] INSTR;
    logic        DREQ;
    logic        DRW;
    logic [29:0] DADDR;
    logic [31:0] DWDATA;
    logic [31:0] DRDATA;
    logic        LDEN;
    logic [3:0]  LDADDR;
    logic [31:0] LDDATA;
    logic        LDACK;
    logic        INIT_DONE;
    logic        ERR;

    toy_mem_responder #(.AW(TAW), .FILL(TFILL)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .IREQ(IREQ), .IADDR(IADDR), .INSTR(INSTR),
        .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR),
        .DWDATA(DWDATA), .DRDATA(DRDATA),
        .LDEN(LDEN), .LDADDR(LDADDR), .LDDATA(LDDATA),
        .LDACK(LDACK), .INIT_DONE(INIT_DONE), .ERR(ERR)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] drd;
        logic        err;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mdl [TD];
    logic [31:0] m_instr;
    logic [31:0] m_drd;
    logic        m_err;
    int          checks = 0;
    int          errors = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [29:0] rand_addr();
        if ($urandom_range(0, 9) == 0)
            return {26'($urandom_range(1, 1000)), 4'($urandom_range(0, 15))};
        return {26'd0, 4'($urandom_range(0, 15))};
    endfunction

    task automatic model_reset();
        m_instr = 32'h0;
        m_drd   = 32'h0;
        m_err   = 1'b0;
    endtask

    task automatic model_fill();
        for (int i = 0; i < TD; i++) mdl[i] = TFILL;
    endtask

    task automatic idle_inputs();
        IREQ = 0; IADDR = '0; DREQ = 0; DRW = 0; DADDR = '0;
        DWDATA = '0; LDEN = 0; LDADDR = '0; LDDATA = '0;
    endtask

    // One RUN-phase cycle: drive at negedge, predict, push, check LDACK.
    task automatic cycle(input logic ireq, input logic [29:0] iaddr,
                         input logic dreq, input logic drw,
                         input logic [29:0] daddr, input logic [31:0] dwdata,
                         input logic lden, input logic [3:0] ldaddr,
                         input logic [31:0] lddata);
        logic i_oor;
        logic d_oor;
        logic ack;
        exp_t e;
        @(negedge CLK);
        IREQ = ireq; IADDR = iaddr; DREQ = dreq; DRW = drw; DADDR = daddr;
        DWDATA = dwdata; LDEN = lden; LDADDR = ldaddr; LDDATA = lddata;
        i_oor = (iaddr >= 30'(TD));
        d_oor = (daddr >= 30'(TD));
        ack   = lden && !(dreq && !drw);
        if (ireq) m_instr = i_oor ? 32'h0 : mdl[iaddr[3:0]];
        if (dreq && drw) m_drd = d_oor ? 32'h0 : mdl[daddr[3:0]];
        if ((ireq && i_oor) || (dreq && d_oor)) m_err = 1'b1;
        e.instr = m_instr;
        e.drd   = m_drd;
        e.err   = m_err;
        q.push_back(e);
        if (dreq && !drw) begin
            if (!d_oor) mdl[daddr[3:0]] = dwdata;
        end else if (ack) begin
            mdl[ldaddr] = lddata;
        end
        #1;
        check("LDACK", {31'b0, LDACK}, {31'b0, ack});
    endtask

    // Clear-sequence edges with random ignored traffic; entered just after a negedge.
    task automatic init_seq(input int n);
        for (int e = 1; e <= n; e++) begin
            IREQ = 1'($urandom); IADDR = rand_addr();
            DREQ = 1'($urandom); DRW = 1'($urandom); DADDR = rand_addr();
            DWDATA = $urandom; LDEN = 1'($urandom);
            LDADDR = 4'($urandom); LDDATA = $urandom;
            #1;
            check("LDACK_init", {31'b0, LDACK}, 32'h0);
            @(posedge CLK);
            #1;
            check("INIT_DONE", {31'b0, INIT_DONE}, {31'b0, (e == TD)});
            check("INSTR_init", INSTR, 32'h0);
            check("DRDATA_init", DRDATA, 32'h0);
            check("ERR_init", {31'b0, ERR}, {31'b0, m_err});
            @(negedge CLK);
        end
        idle_inputs();
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 10) begin
            @(posedge CLK);
            n++;
        end
        #2;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses never observed", q.size());
            q.delete();
        end
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_INSTR"}, INSTR, 32'h0);
        check({tag, "_DRDATA"}, DRDATA, 32'h0);
        check({tag, "_INIT_DONE"}, {31'b0, INIT_DONE}, 32'h0);
        check({tag, "_ERR"}, {31'b0, ERR}, 32'h0);
        check({tag, "_LDACK"}, {31'b0, LDACK}, 32'h0);
    endtask

    // Monitor: every edge that has a pending prediction is compared here.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("INSTR", INSTR, e.instr);
                check("DRDATA", DRDATA, e.drd);
                check("ERR", {31'b0, ERR}, {31'b0, e.err});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        RSTN = 1'b0;
        idle_inputs();
        model_reset();
        repeat (3) @(negedge CLK);
        #1;
        check_reset_outputs("rst");
        @(negedge CLK);
        RSTN = 1'b1;
        init_seq(TD);
        model_fill();

        for (int i = 0; i < TD; i++)
            cycle(1, 30'(i), 1, 1, 30'(TD - 1 - i), 0, 0, 0, 0);

        cycle(0, 0, 0, 0, 0, 0, 1, 4'd3, 32'h1840_0005);
        cycle(1, 30'd3, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

        cycle(0, 0, 1, 0, 30'd5, 32'hA5A5_0000, 0, 0, 0);
        cycle(1, 30'd5, 1, 0, 30'd5, 32'h1234_5678, 0, 0, 0);
        cycle(0, 0, 1, 1, 30'd5, 0, 0, 0, 0);

        cycle(0, 0, 1, 0, 30'd9, 32'h9999_0009, 1, 4'd7, 32'h7777_0007);
        cycle(0, 0, 1, 1, 30'd7, 0, 1, 4'd7, 32'h7777_0007);
        cycle(1, 30'd7, 1, 1, 30'd9, 0, 0, 0, 0);

        cycle(1, 30'd2, 1, 1, 30'd2, 0, 1, 4'd2, 32'h2222_2222);
        cycle(1, 30'd2, 1, 1, 30'd2, 0, 0, 0, 0);

        cycle(0, 0, 1, 0, 30'h10, 32'hBAD0_BAD0, 0, 0, 0);
        cycle(0, 0, 1, 1, 30'h10, 0, 0, 0, 0);
        cycle(1, 30'h0, 1, 1, 30'h0, 0, 0, 0, 0);
        cycle(1, 30'h3FFF_FFFF, 0, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 400; n++)
            cycle(1'($urandom), rand_addr(), 1'($urandom), 1'($urandom),
                  rand_addr(), $urandom, 1'($urandom), 4'($urandom), $urandom);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drain();

        @(negedge CLK);
        idle_inputs();
        RSTN = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("rst_run");
        @(negedge CLK);
        RSTN = 1'b1;
        init_seq(8);
        RSTN = 1'b0;
        #1;
        check_reset_outputs("rst_init");
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;
        init_seq(TD);
        model_fill();

        for (int i = 0; i < TD; i++)
            cycle(1, 30'(TD - 1 - i), 1, 1, 30'(i), 0, 0, 0, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
